// File: rtl/mem_bist_pkg.sv
// Shared types and constants for the memory BIST controller and its pattern generator.
package mem_bist_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        GAP   = 3'd2,
        READ  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [1:0] PAT_ADDR  = 2'd0;
    localparam logic [1:0] PAT_CHK   = 2'd1;
    localparam logic [1:0] PAT_NADDR = 2'd2;
    localparam logic [1:0] PAT_LFSR  = 2'd3;

    // Right-shifting Galois masks; bit k set means tap x^(k+1)
    localparam logic [63:0] LFSR_TAPS_4  = 64'h0000_0000_0000_000C;
    localparam logic [63:0] LFSR_TAPS_8  = 64'h0000_0000_0000_00B8;
    localparam logic [63:0] LFSR_TAPS_16 = 64'h0000_0000_0000_B400;
    localparam logic [63:0] LFSR_TAPS_32 = 64'h0000_0000_8020_0003;
    localparam logic [63:0] LFSR_TAPS_64 = 64'hD800_0000_0000_0000;

    function automatic logic [63:0] lfsr_taps(input int unsigned width);
        logic [63:0] taps;
        case (width)
            32'd4:   taps = LFSR_TAPS_4;
            32'd8:   taps = LFSR_TAPS_8;
            32'd16:  taps = LFSR_TAPS_16;
            32'd32:  taps = LFSR_TAPS_32;
            32'd64:  taps = LFSR_TAPS_64;
            default: taps = LFSR_TAPS_16;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/mem_bist_patgen.sv
// Data pattern generator: combinational pattern from (sel, addr, lfsr) plus a loadable/steppable LFSR.
module mem_bist_patgen
    import mem_bist_pkg::*;
#(
    parameter int          WIDTH      = 16,
    parameter int          ADDR_WIDTH = 6,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [1:0]            sel,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  load,
    input  logic                  step,
    output logic [WIDTH-1:0]      pattern
);
    localparam logic [WIDTH-1:0] SEED_W = WIDTH'(SEED);
    localparam logic [WIDTH-1:0] TAPS   = WIDTH'(lfsr_taps(WIDTH));
    localparam logic [WIDTH-1:0] CHK    = {(WIDTH/2){2'b10}};

    logic [WIDTH-1:0] lfsr_r;
    logic [WIDTH-1:0] lfsr_next_s;

    assign lfsr_next_s = lfsr_r[0] ? ({1'b0, lfsr_r[WIDTH-1:1]} ^ TAPS) : {1'b0, lfsr_r[WIDTH-1:1]};

    // LFSR state: reseeded at the start of each phase, advanced per completed transfer
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_r <= {WIDTH{1'b0}};
        end else if (load) begin
            lfsr_r <= SEED_W;
        end else if (step) begin
            lfsr_r <= lfsr_next_s;
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    // Pattern selection for the current address
    always_comb begin
        pattern = {WIDTH{1'b0}};
        case (sel)
            PAT_ADDR:  pattern = WIDTH'(addr);
            PAT_CHK:   pattern = addr[0] ? ~CHK : CHK;
            PAT_NADDR: pattern = ~(WIDTH'(addr));
            PAT_LFSR:  pattern = lfsr_r;
            default:   pattern = {WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/mem_bist_ctrl.sv
// Memory BIST master: writes a pattern over an address range, reads it back and reports mismatches.
// Define MEM_BIST_TIMEOUT_EN to enable the per-transfer ready timeout.
module mem_bist_ctrl
    import mem_bist_pkg::*;
#(
    parameter int          WIDTH      = 16,
    parameter int          DEPTH      = 64,
    parameter int          ADDR_WIDTH = $clog2(DEPTH),
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int          TIMEOUT    = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] s_loc_i,
    input  logic [ADDR_WIDTH:0]   no_of_loc_i,
    input  logic [1:0]            pattern_sel_i,
    output logic                  valid_o,
    output logic                  wr_rd_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [WIDTH-1:0]      wdata_o,
    input  logic [WIDTH-1:0]      rdata_i,
    input  logic                  ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [ADDR_WIDTH:0]   err_cnt_o,
    output logic [ADDR_WIDTH-1:0] first_err_addr_o,
    output logic                  timeout_o
);
    localparam int                    CNT_W     = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0]      DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                state_r;
    logic [ADDR_WIDTH-1:0] addr_r, s_loc_r, first_err_r, addr_inc_s;
    logic [CNT_W-1:0]      count_r, remain_r, err_cnt_r, n_clamped_s;
    logic [1:0]            sel_r;
    logic                  valid_r, wr_rd_r, busy_r, done_r, pass_r, timeout_r;
    logic                  handshake_s, last_s, mismatch_s, tmo_hit_s, pat_load_s;
    logic [WIDTH-1:0]      pat_s;

    assign handshake_s = valid_r & ready_i;
    assign last_s      = (remain_r == CNT_W'(1));
    assign mismatch_s  = (rdata_i != pat_s);
    assign addr_inc_s  = (addr_r == LAST_ADDR) ? {ADDR_WIDTH{1'b0}} : addr_r + ADDR_WIDTH'(1);
    assign n_clamped_s = (no_of_loc_i > DEPTH_C) ? DEPTH_C : no_of_loc_i;
    assign pat_load_s  = ((state_r == IDLE) & start_i) | (state_r == GAP);

    mem_bist_patgen #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .SEED       (SEED)
    ) u_patgen (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .sel     (sel_r),
        .addr    (addr_r),
        .load    (pat_load_s),
        .step    (handshake_s),
        .pattern (pat_s)
    );

`ifdef MEM_BIST_TIMEOUT_EN
    localparam int               TMO_W   = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] tmo_cnt_r;

    assign tmo_hit_s = valid_r & ~ready_i & (tmo_cnt_r == TMO_MAX);

    // Wait-cycle counter; restarts whenever no request is pending or a handshake completes
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if (!valid_r || ready_i) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if (tmo_cnt_r != TMO_MAX) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end
`else
    logic unused_timeout_s;

    assign tmo_hit_s        = 1'b0;
    assign unused_timeout_s = (TIMEOUT > 0);
`endif

    // Main sequencer with registered handshake and status outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= IDLE;
            addr_r      <= {ADDR_WIDTH{1'b0}};
            s_loc_r     <= {ADDR_WIDTH{1'b0}};
            first_err_r <= {ADDR_WIDTH{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            remain_r    <= {CNT_W{1'b0}};
            err_cnt_r   <= {CNT_W{1'b0}};
            sel_r       <= 2'b00;
            valid_r     <= 1'b0;
            wr_rd_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        sel_r       <= pattern_sel_i;
                        s_loc_r     <= s_loc_i;
                        addr_r      <= s_loc_i;
                        count_r     <= n_clamped_s;
                        remain_r    <= n_clamped_s;
                        err_cnt_r   <= {CNT_W{1'b0}};
                        first_err_r <= {ADDR_WIDTH{1'b0}};
                        pass_r      <= 1'b0;
                        timeout_r   <= 1'b0;
                        busy_r      <= 1'b1;
                        if (n_clamped_s == {CNT_W{1'b0}}) begin
                            state_r <= DONE;
                        end else begin
                            state_r <= WRITE;
                            valid_r <= 1'b1;
                            wr_rd_r <= 1'b1;
                        end
                    end
                end
                WRITE, READ: begin
                    if (tmo_hit_s) begin
                        timeout_r <= 1'b1;
                        err_cnt_r <= {CNT_W{1'b1}};
                        valid_r   <= 1'b0;
                        wr_rd_r   <= 1'b0;
                        state_r   <= DONE;
                    end else if (handshake_s) begin
                        addr_r   <= addr_inc_s;
                        remain_r <= remain_r - CNT_W'(1);
                        // The read phase scores the word present in this handshake cycle
                        if (state_r == READ && mismatch_s) begin
                            if (err_cnt_r == {CNT_W{1'b0}}) begin
                                first_err_r <= addr_r;
                            end
                            if (err_cnt_r != {CNT_W{1'b1}}) begin
                                err_cnt_r <= err_cnt_r + CNT_W'(1);
                            end
                        end
                        if (last_s) begin
                            valid_r <= 1'b0;
                            wr_rd_r <= 1'b0;
                            state_r <= (state_r == WRITE) ? GAP : DONE;
                        end
                    end
                end
                GAP: begin
                    addr_r   <= s_loc_r;
                    remain_r <= count_r;
                    valid_r  <= 1'b1;
                    wr_rd_r  <= 1'b0;
                    state_r  <= READ;
                end
                DONE: begin
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    pass_r  <= (err_cnt_r == {CNT_W{1'b0}});
                    state_r <= IDLE;
                end
                default: begin
                    valid_r <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign valid_o          = valid_r;
    assign wr_rd_o          = wr_rd_r;
    assign addr_o           = addr_r;
    assign wdata_o          = (state_r == WRITE) ? pat_s : {WIDTH{1'b0}};
    assign busy_o           = busy_r;
    assign done_o           = done_r;
    assign pass_o           = pass_r;
    assign err_cnt_o        = err_cnt_r;
    assign first_err_addr_o = first_err_r;
    assign timeout_o        = timeout_r;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: behavioural memory with random ready, transaction-level reference model.
module tb_mem_bist_ctrl;
    localparam int          WIDTH = 16;
    localparam int          DEPTH = 64;
    localparam int          AW    = 6;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic             clk = 1'b0, rst = 1'b1, start = 1'b0, ready = 1'b0;
    logic [AW-1:0]    s_loc = '0, addr, first_err;
    logic [AW:0]      nloc = '0, err_cnt;
    logic [1:0]       psel = '0;
    logic             valid, wr_rd, busy, done, pass, timeout;
    logic [WIDTH-1:0] wdata, rdata;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    q_waddr [$];
    logic [WIDTH-1:0] q_wdata [$];
    logic [AW-1:0]    q_raddr [$];
    int checks = 0, failures = 0;
    int rdy_pct = 100, busy_novalid = 0, valid_seen = 0;
    logic pend = 1'b0, prev_w = 1'b0;
    logic [AW-1:0] prev_a = '0;
    logic [WIDTH-1:0] prev_d = '0;

    mem_bist_ctrl dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .s_loc_i(s_loc), .no_of_loc_i(nloc),
        .pattern_sel_i(psel), .valid_o(valid), .wr_rd_o(wr_rd), .addr_o(addr), .wdata_o(wdata),
        .rdata_i(rdata), .ready_i(ready), .busy_o(busy), .done_o(done), .pass_o(pass),
        .err_cnt_o(err_cnt), .first_err_addr_o(first_err), .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    assign rdata = mem[addr];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Reference pattern: value the i-th word of a phase at address a must hold
    function automatic logic [15:0] exp_pat(input int sel, input int a, input int i);
        logic [15:0] v;
        case (sel)
            0: v = 16'(a);
            1: v = (a % 2 == 0) ? 16'hAAAA : 16'h5555;
            2: v = ~16'(a);
            default: begin
                v = SEED;
                for (int j = 0; j < i; j++) v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
            end
        endcase
        return v;
    endfunction

    // Memory ready: random each cycle with probability rdy_pct percent
    initial begin
        forever begin
            @(posedge clk);
            #1;
            ready = ($urandom_range(99) < rdy_pct);
        end
    end

    // Transfer monitor and behavioural memory
    always @(negedge clk) begin
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (pend && !timeout) chk("req_hold", {valid, wr_rd, addr, wdata}, {1'b1, prev_w, prev_a, prev_d});
            if (valid && !wr_rd) chk("rd_wdata_zero", 64'(wdata), 64'h0);
            if (valid && ready) begin
                if (wr_rd) begin
                    mem[addr] = wdata;
                    q_waddr.push_back(addr);
                    q_wdata.push_back(wdata);
                end else begin
                    q_raddr.push_back(addr);
                end
            end
            if (busy && !valid) busy_novalid++;
            if (valid) valid_seen++;
            pend = valid && !ready;
            prev_w = wr_rd; prev_a = addr; prev_d = wdata;
        end
    end

    task automatic clear_obs();
        q_waddr.delete(); q_wdata.delete(); q_raddr.delete();
        busy_novalid = 0; valid_seen = 0;
    endtask

    task automatic run_test(input int s, input int n, input int pat, input bit corrupt, input bit pulse);
        int nc, cyc, exp_err, exp_first, a;
        bit corrupted;
        nc = (n > DEPTH) ? DEPTH : n;
        clear_obs();
        s_loc = 6'(s); nloc = 7'(n); psel = 2'(pat); start = 1'b1;
        step();
        start = 1'b0;
        s_loc = 6'($urandom); nloc = 7'($urandom); psel = 2'($urandom);
        cyc = 0; corrupted = 1'b0;
        while (!done && cyc < 20000) begin
            start = (pulse && cyc == 3);
            if (corrupt && !corrupted && valid && !wr_rd) begin
                mem[5] = 16'h0000; mem[9] = 16'hFFFF; corrupted = 1'b1;
            end
            step();
            cyc++;
        end
        start = 1'b0;
        chk("done_seen", 64'(done), 64'h1);
        chk("busy_at_done", 64'(busy), 64'h0);
        chk("wr_count", 64'(q_waddr.size()), 64'(nc));
        chk("rd_count", 64'(q_raddr.size()), 64'(nc));
        exp_err = 0; exp_first = 0;
        for (int i = 0; i < nc; i++) begin
            a = (s + i) % DEPTH;
            if (i < q_waddr.size()) begin
                chk("wr_addr", 64'(q_waddr[i]), 64'(a));
                chk("wr_data", 64'(q_wdata[i]), 64'(exp_pat(pat, a, i)));
            end
            if (i < q_raddr.size()) chk("rd_addr", 64'(q_raddr[i]), 64'(a));
            if (mem[a] !== exp_pat(pat, a, i)) begin
                if (exp_err == 0) exp_first = a;
                exp_err++;
            end
        end
        chk("err_cnt", 64'(err_cnt), 64'(exp_err));
        chk("first_err", 64'(first_err), 64'(exp_first));
        chk("pass", 64'(pass), 64'(exp_err == 0));
        chk("busy_idle_cycles", 64'(busy_novalid), (nc == 0) ? 64'd1 : 64'd2);
        chk("timeout_clear", 64'(timeout), 64'h0);
        step();
        chk("done_one_cycle", 64'(done), 64'h0);
    endtask

    initial begin
        int cyc;
        bit done_seen;
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
        step(); step();
        chk("reset_outputs", {valid, wr_rd, addr, wdata, busy, done, pass, err_cnt, first_err, timeout}, 64'h0);
        rst = 1'b0;
        step();

        // Directed scenarios
        run_test(0, 64, 0, 1'b0, 1'b0);
        run_test(60, 8, 1, 1'b0, 1'b0);
        run_test(0, 64, 3, 1'b1, 1'b0);
        run_test(5, 64, 2, 1'b0, 1'b1);
        run_test(10, 100, 2, 1'b0, 1'b0);

        // Zero-length run: done two cycles after start, no request issued
        clear_obs();
        s_loc = 6'd17; nloc = 7'd0; psel = 2'd1; start = 1'b1;
        step();
        start = 1'b0;
        chk("zero_done_early", 64'(done), 64'h0);
        chk("zero_busy", 64'(busy), 64'h1);
        step();
        chk("zero_done", 64'(done), 64'h1);
        chk("zero_pass", 64'(pass), 64'h1);
        chk("zero_err", 64'(err_cnt), 64'h0);
        chk("zero_no_valid", 64'(valid_seen), 64'h0);
        step();

        // Reset in the middle of the read phase
        clear_obs();
        s_loc = 6'd0; nloc = 7'd64; psel = 2'd0; start = 1'b1;
        step();
        start = 1'b0;
        cyc = 0;
        while (!(valid && !wr_rd && addr == 6'd20) && cyc < 2000) begin
            step();
            cyc++;
        end
        chk("rst_reached_read20", 64'(valid && !wr_rd && addr == 6'd20), 64'h1);
        rst = 1'b1;
        step();
        chk("rst_mid_outputs", {valid, wr_rd, addr, wdata, busy, done, pass, err_cnt, first_err, timeout}, 64'h0);
        rst = 1'b0;
        step();
        run_test(33, 40, 3, 1'b0, 1'b0);

        // Memory that never answers
        clear_obs();
        rdy_pct = 0;
        s_loc = 6'd3; nloc = 7'd10; psel = 2'd2; start = 1'b1;
        step();
        start = 1'b0;
`ifdef MEM_BIST_TIMEOUT_EN
        cyc = 0;
        while (!done && cyc < 200) begin
            step();
            cyc++;
        end
        chk("tmo_done", 64'(done), 64'h1);
        chk("tmo_flag", 64'(timeout), 64'h1);
        chk("tmo_err_cnt", 64'(err_cnt), 64'h7F);
        chk("tmo_pass", 64'(pass), 64'h0);
        chk("tmo_valid_cycles", 64'(valid_seen), 64'd32);
        chk("tmo_no_writes", 64'(q_waddr.size()), 64'h0);
        rdy_pct = 100;
        step();
`else
        done_seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            done_seen = done_seen | done;
        end
        chk("stall_no_done", 64'(done_seen), 64'h0);
        chk("stall_valid", {valid, wr_rd, addr, busy, timeout}, {1'b1, 1'b1, 6'd3, 1'b1, 1'b0});
        rdy_pct = 100;
        cyc = 0;
        while (!done && cyc < 500) begin
            step();
            cyc++;
        end
        chk("stall_done", 64'(done), 64'h1);
        chk("stall_pass", {pass, err_cnt, timeout}, {1'b1, 7'd0, 1'b0});
        step();
`endif

        // Randomized runs
        for (int k = 0; k < 4; k++) begin
            rdy_pct = $urandom_range(30, 100);
            run_test($urandom_range(63), $urandom_range(70), $urandom_range(3), 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_bist_ctrl.md
Name: mem_bist_ctrl

Overview:
- Upstream master for the single-port `memory` block; drives its `valid_i`/`wr_rd_i`/`addr_i`/`wdata_i` and consumes its `rdata_o`/`ready_o`.
- On a start pulse it writes a programmable data pattern to a contiguous address range, then reads the range back and compares each word.
- Reports pass/fail, a saturating error count and the first failing address to a host or testbench.

Parameters:
- WIDTH, 16, data word width; must match the memory.
- DEPTH, 64, number of memory locations.
- ADDR_WIDTH, $clog2(DEPTH), address width.
- SEED, 16'hACE1, LFSR seed for pattern 3; truncated or zero-extended to WIDTH.
- TIMEOUT, 32, maximum cycles to wait for `ready_i` per transfer (used only with the macro).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  start pulse; sampled only in IDLE.
- s_loc_i  in  ADDR_WIDTH  start address; captured at start.
- no_of_loc_i  in  ADDR_WIDTH+1  number of locations (0..DEPTH); captured at start.
- pattern_sel_i  in  2  pattern select; captured at start.
- valid_o  out  1  request to memory.
- wr_rd_o  out  1  1 = write, 0 = read.
- addr_o  out  ADDR_WIDTH  memory address.
- wdata_o  out  WIDTH  write data.
- rdata_i  in  WIDTH  memory read data.
- ready_i  in  1  memory ready; a transfer completes on a rising edge where `valid_o && ready_i`.
- busy_o  out  1  high from the cycle after start until DONE.
- done_o  out  1  one-cycle completion pulse.
- pass_o  out  1  1 when err_cnt_o == 0; valid from `done_o` until the next start.
- err_cnt_o  out  ADDR_WIDTH+1  mismatch count; saturates at all-ones.
- first_err_addr_o  out  ADDR_WIDTH  address of the first mismatch; 0 if none.
- timeout_o  out  1  sticky transfer-timeout flag; tied 0 without the macro.

Behaviour:
- Clock and reset: one clock, `clk_i`; reset `rst_i` is synchronous and active-high.
- Reset values: all outputs 0; state IDLE. A reset during any phase aborts the test; the next edge yields all outputs at 0.
- Patterns, computed from the address (or LFSR step):
  - 0: data = address, zero-extended or truncated to WIDTH.
  - 1: checkerboard; addr[0]=0 gives {WIDTH/2{2'b10}}, addr[0]=1 gives the inverse.
  - 2: data = ~address, zero-extended to WIDTH before inversion.
  - 3: Galois LFSR; taps x^16+x^14+x^13+x^11+1 for WIDTH=16, otherwise a fixed maximal polynomial in the package. Reseeded to SEED at the start of each phase and advanced once per completed transfer.
- State machine: IDLE -> WRITE -> GAP -> READ -> DONE -> IDLE.
- IDLE:
  - `start_i` high captures the inputs and clears err_cnt_o, first_err_addr_o, pass_o and timeout_o.
  - If no_of_loc_i == 0, go straight to DONE (pass_o=1).
  - Otherwise go to WRITE.
  - `start_i` outside IDLE is ignored.
- WRITE:
  - `valid_o` rises the cycle after start is accepted.
  - `valid_o`=1, `wr_rd_o`=1. Address, data and valid are held stable until handshake.
  - On handshake the address increments modulo DEPTH (wrap 63->0) and the remaining count decrements.
  - Back-to-back: the next request is presented the cycle after handshake.
  - After the last write, go to GAP.
- GAP: exactly one cycle with `valid_o`=0; pattern generator reloaded.
- READ:
  - `valid_o`=1, `wr_rd_o`=0, `wdata_o`=0.
  - `rdata_i` is sampled in the handshake cycle and compared with the expected pattern.
  - On mismatch: err_cnt_o increments (saturating). If it was 0, first_err_addr_o takes `addr_o`.
  - After the last read, go to DONE.
- DONE: `done_o`=1 and `busy_o`=0 for one cycle; pass_o updated; return to IDLE.
- Count/address boundaries:
  - s_loc + no_of_loc > DEPTH wraps around.
  - no_of_loc_i > DEPTH is clamped to DEPTH.

Optional Feature:
- Macro: MEM_BIST_TIMEOUT_EN.
- With it: a per-transfer counter clears on every handshake or new request. If `valid_o` is high for TIMEOUT cycles without `ready_i`:
  - timeout_o is set.
  - err_cnt_o is forced to all-ones.
  - The FSM goes to DONE with pass_o=0.
- Without it: no counter; the block waits indefinitely; timeout_o is constant 0.

Decomposition:
- Package mem_bist_pkg holds:
  - state enum (IDLE, WRITE, GAP, READ, DONE);
  - pattern-select constants PAT_ADDR, PAT_CHK, PAT_NADDR, PAT_LFSR;
  - LFSR tap constants.
- One sub-module, mem_bist_patgen: combinational pattern from (sel, addr, lfsr_state) plus a registered LFSR with load and step inputs. Shared by the write and read phases.

Test Plan:
- DEPTH=64, WIDTH=16, real `memory`. start, s_loc=0, no_of_loc=64, pat=0 -> 64 writes, a 1-cycle gap, 64 reads; done_o pulse; pass_o=1, err_cnt_o=0.
- s_loc=60, no_of_loc=8, pat=1 -> addresses 60..63 then 0..3 in both phases; wdata alternates AAAA/5555; pass_o=1.
- pat=3, full range; between the phases the bench backdoor-writes mem[5]=16'h0000 and mem[9]=16'hFFFF -> err_cnt_o=2, first_err_addr_o=5, pass_o=0.
- no_of_loc=0 -> done_o exactly 2 cycles after start, valid_o never high, pass_o=1; start_i pulsed while busy -> ignored.
- rst_i asserted mid-READ at location 20 -> all outputs 0 next edge; a following start runs cleanly.
- MEM_BIST_TIMEOUT_EN, ready_i held 0 -> after 32 cycles timeout_o=1, err_cnt_o=7'h7F, pass_o=0, done_o pulses.
